// File: rtl/satd_block_feeder_if.sv
// rtl/satd_block_feeder_if.sv - Pixel-row and diff-stage bundle for the SATD block feeder
interface satd_block_feeder_if #(
    parameter int BIT_DEPTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [4*BIT_DEPTH-1:0] in_orig;
    logic [4*BIT_DEPTH-1:0] in_ref;
    logic                   enable_diff;
    logic                   out_valid;
    logic [1:0]             out_row;
    logic [4*BIT_DEPTH-1:0] out_orig;
    logic [4*BIT_DEPTH-1:0] out_ref;
    logic                   block_done;
    logic                   underrun;
    logic [1:0]             fill_level;

    // Fetch logic and SATD controller side
    modport master (
        output in_valid, in_orig, in_ref, enable_diff,
        input  in_ready, out_valid, out_row, out_orig, out_ref,
        input  block_done, underrun, fill_level
    );

    // Feeder side
    modport slave (
        input  in_valid, in_orig, in_ref, enable_diff,
        output in_ready, out_valid, out_row, out_orig, out_ref,
        output block_done, underrun, fill_level
    );
endinterface

// File: rtl/satd_block_feeder.sv
// rtl/satd_block_feeder.sv - Two-bank 4x4 block buffer streaming rows into the SATD diff stage
module satd_block_feeder #(
    parameter int BIT_DEPTH = 8
) (
    input logic                clk,
    input logic                reset,
    satd_block_feeder_if.slave bus
);
    localparam int ROW_W = 4 * BIT_DEPTH;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t state, state_next;

    logic [ROW_W-1:0] bank_orig [2][4];
    logic [ROW_W-1:0] bank_ref  [2][4];

    logic             wr_bank;
    logic [1:0]       wr_row;
    logic             rd_bank;
    logic [1:0]       rd_row;
    logic [1:0]       rd_row_next;
    logic [1:0]       fill_level;
    logic             enable_diff_q;
    logic             underrun_q;
    logic [ROW_W-1:0] out_orig_q;
    logic [ROW_W-1:0] out_ref_q;

    logic             ready;
    logic             start;
    logic             write_fire;
    logic             bank_complete;
    logic             bank_release;
    logic             load_first;
    logic             load_next;
    logic             set_underrun;

    assign ready         = (fill_level != 2'd2);
    assign start         = bus.enable_diff && !enable_diff_q;
    assign write_fire    = bus.in_valid && ready;
    assign bank_complete = write_fire && (wr_row == 2'd3);
    assign rd_row_next   = rd_row + 2'd1;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a request starts a block only when a full bank is waiting
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start && fill_level != 2'd0) state_next = STREAM;
            STREAM:  if (rd_row == 2'd3) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        load_first   = 1'b0;
        load_next    = 1'b0;
        bank_release = 1'b0;
        set_underrun = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (fill_level != 2'd0) load_first = 1'b1;
                    else set_underrun = 1'b1;
                end
            end
            STREAM: begin
                if (rd_row == 2'd3) bank_release = 1'b1;
                else load_next = 1'b1;
            end
            default: ;
        endcase
    end

    // Row storage; contents need no reset since fill_level gates every read
    always_ff @(posedge clk) begin
        if (write_fire) begin
            bank_orig[wr_bank][wr_row] <= bus.in_orig;
            bank_ref[wr_bank][wr_row]  <= bus.in_ref;
        end
    end

    // Write pointer advances per accepted row and flips bank after the 4th
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_row  <= 2'd0;
            wr_bank <= 1'b0;
        end else if (write_fire) begin
            wr_row <= wr_row + 2'd1;
            if (wr_row == 2'd3) wr_bank <= !wr_bank;
        end
    end

    // Read pointer, request edge history and sticky underrun flag
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_row        <= 2'd0;
            rd_bank       <= 1'b0;
            enable_diff_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            enable_diff_q <= bus.enable_diff;
            if (set_underrun) underrun_q <= 1'b1;
            if (load_first) begin
                rd_row <= 2'd0;
            end else if (load_next) begin
                rd_row <= rd_row_next;
            end else if (bank_release) begin
                rd_row  <= 2'd0;
                rd_bank <= !rd_bank;
            end
        end
    end

    // Registered output rows; held between blocks
    always_ff @(posedge clk) begin
        if (reset) begin
            out_orig_q <= '0;
            out_ref_q  <= '0;
        end else if (load_first) begin
            out_orig_q <= bank_orig[rd_bank][0];
            out_ref_q  <= bank_ref[rd_bank][0];
        end else if (load_next) begin
            out_orig_q <= bank_orig[rd_bank][rd_row_next];
            out_ref_q  <= bank_ref[rd_bank][rd_row_next];
        end
    end

    // Full-bank count; a completion and a release in one cycle cancel out
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_level <= 2'd0;
        end else begin
            case ({bank_complete, bank_release})
                2'b10:   fill_level <= fill_level + 2'd1;
                2'b01:   fill_level <= fill_level - 2'd1;
                default: fill_level <= fill_level;
            endcase
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = (state == STREAM);
    assign bus.out_row    = rd_row;
    assign bus.out_orig   = out_orig_q;
    assign bus.out_ref    = out_ref_q;
    assign bus.block_done = (state == STREAM) && (rd_row == 2'd3);
    assign bus.underrun   = underrun_q;
    assign bus.fill_level = fill_level;
endmodule
